// File: rtl/ac_dot_acc.sv
// ac_dot_acc: sums a vector of up to LEN unsigned 16-bit products into a
// saturating ACC_W-bit result, presented over an output valid/ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1. A producer holding valid must keep its data
// stable until that edge. in_ready and out_valid depend on the FSM state only.
module ac_dot_acc #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [8:0]       out_cnt,
  output logic             out_sat,
  output logic             dbg_state
);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  // Count value held while the LEN-th product is being offered.
  localparam logic [8:0] CNT_LAST = 9'(LEN - 1);

  state_t             r_state;
  state_t             w_next_state;

  logic [ACC_W-1:0]   r_acc;
  logic [8:0]         r_cnt;
  logic               r_sat;
  logic [ACC_W-1:0]   r_out_sum;
  logic [8:0]         r_out_cnt;
  logic               r_out_sat;

  logic               w_accept;
  logic               w_close;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_sat_next;
  logic [8:0]         w_cnt_inc;

  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_out_sum;
  assign out_cnt   = r_out_cnt;
  assign out_sat   = r_out_sat;
  assign dbg_state = r_state;

  // One extra bit catches the carry out of the accumulator for saturation.
  assign w_accept   = in_valid & in_ready;
  assign w_sum_ext  = {1'b0, r_acc} + (ACC_W + 1)'(in_prod);
  assign w_carry    = w_sum_ext[ACC_W];
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign w_sat_next = r_sat | w_carry;
  assign w_cnt_inc  = r_cnt + 9'd1;
  // in_last and the length limit together still close the vector only once.
  assign w_close    = w_accept & (in_last | (r_cnt == CNT_LAST));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: close a vector into DONE, release it on the output handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ACC:   if (w_close)   w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_ACC;
      default: w_next_state = S_ACC;
    endcase
  end

  // Accumulate accepted products; snapshot the result on close; clear on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_out_sum <= '0;
      r_out_cnt <= '0;
      r_out_sat <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_inc;
      r_sat <= w_sat_next;
      if (w_close) begin
        r_out_sum <= w_acc_next;
        r_out_cnt <= w_cnt_inc;
        r_out_sat <= w_sat_next;
      end
    end else if ((r_state == S_DONE) && out_ready) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end
  end

endmodule
